// File: rtl/ser_frame.sv
// ser_frame: flow-controlled parallel-to-serial converter with a one-word
// holding buffer and frame start/end markers.
module ser_frame #(
    parameter int DATA_W    = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic [DATA_W-1:0] word;
    logic              active;
    logic [CW-1:0]     cnt;

    logic              last_bit;
    logic              advance;
    logic              accept;
    logic              load;
    logic [CW-1:0]     idx;

    assign last_bit = (cnt == LAST);
    assign advance  = active & enable;
    assign accept   = din_valid & ~hold_full;
    // An idle shifter pulls the held word regardless of enable; a running
    // one only takes it as its last bit leaves so words abut.
    assign load     = hold_full & (~active | (advance & last_bit));

    // Holding buffer: capture on handshake, release on load.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shift stage: load, advance or wrap the bit counter; stall when disabled.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            word   <= '0;
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            word   <= hold;
            active <= 1'b1;
            cnt    <= '0;
        end else if (advance) begin
            if (last_bit) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Bit position within the word for the current count.
    always_comb begin
        idx = cnt;
        if (!LSB_FIRST)
            idx = LAST - cnt;
    end

    assign din_ready   = ~hold_full;
    assign dout_valid  = advance;
    assign dout        = advance & word[idx];
    assign frame_start = advance & (cnt == '0);
    assign frame_end   = advance & last_bit;
    assign busy        = active | hold_full;

endmodule

// File: tb/tb_ser_frame.sv
// tb_ser_frame: directed vectors for ser_frame in 32-bit LSB-first,
// 32-bit MSB-first and 5-bit LSB-first configurations.
module tb_ser_frame;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;

    logic [31:0] din_a = '0;
    logic        dv_a = 1'b0;
    logic        rdy_a, dout_a, ov_a, fs_a, fe_a, busy_a;

    logic [31:0] din_b = '0;
    logic        dv_b = 1'b0;
    logic        rdy_b, dout_b, ov_b, fs_b, fe_b, busy_b;

    logic [4:0]  din_c = '0;
    logic        dv_c = 1'b0;
    logic        rdy_c, dout_c, ov_c, fs_c, fe_c, busy_c;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    ser_frame #(.DATA_W(32), .LSB_FIRST(1'b1)) u_a (
        .clock(clock), .rst(rst), .enable(enable),
        .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
        .dout(dout_a), .dout_valid(ov_a), .frame_start(fs_a),
        .frame_end(fe_a), .busy(busy_a)
    );

    ser_frame #(.DATA_W(32), .LSB_FIRST(1'b0)) u_b (
        .clock(clock), .rst(rst), .enable(enable),
        .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
        .dout(dout_b), .dout_valid(ov_b), .frame_start(fs_b),
        .frame_end(fe_b), .busy(busy_b)
    );

    ser_frame #(.DATA_W(5), .LSB_FIRST(1'b1)) u_c (
        .clock(clock), .rst(rst), .enable(enable),
        .din(din_c), .din_valid(dv_c), .din_ready(rdy_c),
        .dout(dout_c), .dout_valid(ov_c), .frame_start(fs_c),
        .frame_end(fe_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] w;
    logic [31:0] w2;
    logic [9:0]  seq5;
    int          vcnt;

    initial begin
        // reset
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst din_ready", 64'(rdy_a), 64'd1);
        chk("rst busy", 64'(busy_a), 64'd0);
        chk("rst dout", 64'(dout_a), 64'd0);
        chk("rst dout_valid", 64'(ov_a), 64'd0);
        chk("rst frame_start", 64'(fs_a), 64'd0);
        chk("rst frame_end", 64'(fe_a), 64'd0);
        chk("rst c din_ready", 64'(rdy_c), 64'd1);

        // single word, LSB first
        w = 32'hA5A5_0F0F;
        din_a = w;
        dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        chk("a1 ready after accept", 64'(rdy_a), 64'd0);
        chk("a1 busy after accept", 64'(busy_a), 64'd1);
        chk("a1 no output yet", 64'(ov_a), 64'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("a1 dout[%0d]", i), 64'(dout_a), 64'(w[i]));
            chk($sformatf("a1 valid[%0d]", i), 64'(ov_a), 64'd1);
            chk($sformatf("a1 fs[%0d]", i), 64'(fs_a), 64'(i == 0));
            chk($sformatf("a1 fe[%0d]", i), 64'(fe_a), 64'(i == 31));
            tick();
        end
        chk("a1 underrun valid", 64'(ov_a), 64'd0);
        chk("a1 underrun dout", 64'(dout_a), 64'd0);
        chk("a1 idle busy", 64'(busy_a), 64'd0);

        // single word, MSB first
        w = 32'h8000_0001;
        din_b = w;
        dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("b dout[%0d]", i), 64'(dout_b), 64'(w[31-i]));
            chk($sformatf("b valid[%0d]", i), 64'(ov_b), 64'd1);
            tick();
        end
        chk("b end valid", 64'(ov_b), 64'd0);

        // back-to-back stream
        din_a = 32'hFFFF_FFFF;
        dv_a = 1'b1;
        tick();
        chk("bb ready held word", 64'(rdy_a), 64'd0);
        din_a = 32'h0000_0000;
        tick();
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("bb dout[%0d]", i), 64'(dout_a), 64'(i < 32));
            chk($sformatf("bb valid[%0d]", i), 64'(ov_a), 64'd1);
            chk($sformatf("bb fs[%0d]", i), 64'(fs_a),
                64'(i == 0 || i == 32));
            chk($sformatf("bb fe[%0d]", i), 64'(fe_a),
                64'(i == 31 || i == 63));
            chk($sformatf("bb ready[%0d]", i), 64'(rdy_a),
                64'(i == 0 || i >= 32));
            tick();
            if (i == 0)
                dv_a = 1'b0;
        end
        chk("bb end valid", 64'(ov_a), 64'd0);
        chk("bb end busy", 64'(busy_a), 64'd0);

        // stall at bit 10
        w = 32'hC3A5_5C3A;
        din_a = w;
        dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        tick();
        vcnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                enable = 1'b0;
                #1;
                for (int s = 0; s < 5; s++) begin
                    chk($sformatf("st stall dout %0d", s), 64'(dout_a), 64'd0);
                    chk($sformatf("st stall valid %0d", s), 64'(ov_a), 64'd0);
                    tick();
                end
                enable = 1'b1;
                #1;
            end
            chk($sformatf("st dout[%0d]", i), 64'(dout_a), 64'(w[i]));
            if (ov_a)
                vcnt++;
            tick();
        end
        chk("st valid count", 64'(vcnt), 64'd32);
        chk("st end valid", 64'(ov_a), 64'd0);

        // reset mid-word with a word held
        din_a = 32'hFFFF_FFFF;
        dv_a = 1'b1;
        tick();
        din_a = 32'hAAAA_5555;
        tick();
        tick();
        dv_a = 1'b0;
        repeat (16) tick();
        chk("mr busy before", 64'(busy_a), 64'd1);
        chk("mr ready before", 64'(rdy_a), 64'd0);
        chk("mr valid before", 64'(ov_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr async busy", 64'(busy_a), 64'd0);
        chk("mr async ready", 64'(rdy_a), 64'd1);
        chk("mr async valid", 64'(ov_a), 64'd0);
        chk("mr async dout", 64'(dout_a), 64'd0);
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (ov_a || busy_a)
                vcnt++;
            tick();
        end
        chk("mr nothing emitted", 64'(vcnt), 64'd0);

        // 5-bit: load from idle while disabled, then back-to-back pair
        enable = 1'b0;
        din_c = 5'b10110;
        dv_c = 1'b1;
        tick();
        din_c = 5'b01001;
        tick();
        chk("c load w/o enable ready", 64'(rdy_c), 64'd1);
        chk("c load w/o enable busy", 64'(busy_c), 64'd1);
        chk("c disabled valid", 64'(ov_c), 64'd0);
        tick();
        dv_c = 1'b0;
        chk("c second held", 64'(rdy_c), 64'd0);
        enable = 1'b1;
        #1;
        seq5 = 10'b0100110110;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("c dout[%0d]", i), 64'(dout_c), 64'(seq5[i]));
            chk($sformatf("c valid[%0d]", i), 64'(ov_c), 64'd1);
            chk($sformatf("c fs[%0d]", i), 64'(fs_c), 64'(i == 0 || i == 5));
            chk($sformatf("c fe[%0d]", i), 64'(fe_c), 64'(i == 4 || i == 9));
            tick();
        end
        chk("c no sixth bit", 64'(ov_c), 64'd0);
        chk("c idle busy", 64'(busy_c), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
